rs232_tx_arbiter: RTL and testbench
===================================

Name: rs232_tx_arbiter

Overview:
Shares one rs232_send transmitter between NUM_PORTS byte-stream requesters, with packet-level round-robin arbitration.
- A granted port keeps the transmitter until its last byte is accepted, so packets never interleave on the serial line.
- Optionally prepends a header byte that identifies the source port, so the host can demultiplex.
- Sits between application producers (counters, status reporters) and the rs232_send data/enable/ready interface.

Parameters:
NUM_PORTS, 4, number of requesters; legal range 2..16.
HEADER_ENABLE, 1, 1 = send header byte {4'hA, port_index[3:0]} before each packet; 0 = no header.
IDLE_TIMEOUT, 1024, cycles a granted port may leave req_valid low before its grant is revoked; 0 disables the timeout.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_data  input  8*NUM_PORTS  byte from port i on bits [8i+7:8i].
req_valid  input  NUM_PORTS  port i has a byte on req_data.
req_last  input  NUM_PORTS  port i's current byte ends its packet.
req_ready  output  NUM_PORTS  port i's byte is accepted this cycle.
tx_data  output  8  byte to rs232_send.
tx_enable  output  1  tx_data is valid.
tx_ready  input  1  rs232_send accepts tx_data this cycle.
grant  output  NUM_PORTS  one-hot owner of the transmitter; all zero when idle.
busy  output  1  high in the HEADER and DATA states.

Behaviour:
- Transfer rule: a byte moves on every rising edge where tx_enable && tx_ready.
  - Requester side: port i handshakes on req_valid[i] && req_ready[i].
  - Requesters hold req_data, req_valid and req_last stable until accepted.
- Registered state: state (IDLE / HEADER / DATA), grant, round-robin pointer last_idx, timeout counter.
- Reset values (async, while reset_n is low): state=IDLE, grant=0, last_idx=NUM_PORTS-1 so port 0 has first priority, counter=0.
- Output values in reset and in IDLE: tx_enable=0, tx_data=0, req_ready=0, busy=0.
- IDLE:
  - If any req_valid is high, select the first valid port searching last_idx+1, last_idx+2, ... with modulo-NUM_PORTS wrap.
  - Register the one-hot grant and go to HEADER (HEADER_ENABLE=1) or DATA (HEADER_ENABLE=0).
  - Arbitration latency: valid at edge t gives grant and tx_enable at cycle t+1. No request is accepted in the arbitration cycle itself.
- HEADER:
  - tx_enable=1, tx_data={4'hA, idx}, req_ready=0.
  - On accept, go to DATA.
  - The header is sent even if the granted port drops req_valid.
- DATA:
  - tx_data=req_data[g], tx_enable=req_valid[g], req_ready[g]=tx_ready; all other req_ready bits are 0. These are combinational from the grant.
  - On accept with req_last[g]=1: last_idx<=g, grant<=0, go to IDLE.
  - Accept with req_last[g]=0: stay in DATA.
- Timeout (DATA only, IDLE_TIMEOUT>0):
  - The counter increments each cycle req_valid[g] is low and clears on each accept and on entry to DATA.
  - When it reaches IDLE_TIMEOUT: last_idx<=g, go to IDLE. No byte is emitted and the packet is truncated.
- Back-to-back packets: a port's next packet re-arbitrates, with at least one IDLE cycle between packets.
- Fairness: with all ports continuously requesting, grant order is 0,1,2,...,NUM_PORTS-1,0,...
- tx_ready low holds tx_enable and tx_data unchanged. There is no bound on backpressure and the timeout does not run while req_valid[g] is high.
- Reset mid-packet aborts immediately: outputs return to reset values and the partial packet is not resumed.
- Non-granted ports see req_ready=0 regardless of their req_valid.

Test Plan:
1. Single packet, HEADER_ENABLE=1, tx_ready=1: port 2 sends 0x11, 0x22, 0x33 (last on 0x33) -> tx stream 0xA2, 0x11, 0x22, 0x33. busy is high for 4 cycles, then grant=0.
2. Simultaneous requests: ports 0 and 1 assert at the same edge after reset, each with a 2-byte packet -> the port-0 packet completes first (0xA0 ...), then the port-1 packet (0xA1 ...), with no interleaving.
3. Round-robin: all 4 ports request continuously with 1-byte packets -> headers appear in order A0, A1, A2, A3, A0, and req_ready is never high on a non-granted port.
4. Backpressure: tx_ready held low 50 cycles mid-packet -> tx_data and tx_enable are stable, req_ready[g]=0, no byte is lost or duplicated once tx_ready returns.
5. Timeout, IDLE_TIMEOUT=8: port 1 sends header plus 1 non-last byte, then drops valid -> returns to IDLE exactly 8 cycles after the last accept. A pending port 2 is granted next.
6. Reset: reset_n pulsed low mid-DATA -> tx_enable=0 and grant=0 asynchronously. The next arbitration starts at port 0.

Source files
------------

// File: rtl/rs232_tx_arbiter_if.sv
// rtl/rs232_tx_arbiter_if.sv - requester/transmitter bundle for the rs232 tx arbiter
interface rs232_tx_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [8*NUM_PORTS-1:0] req_data;
  logic [NUM_PORTS-1:0]   req_valid;
  logic [NUM_PORTS-1:0]   req_last;
  logic [NUM_PORTS-1:0]   req_ready;
  logic [7:0]             tx_data;
  logic                   tx_enable;
  logic                   tx_ready;
  logic [NUM_PORTS-1:0]   grant;
  logic                   busy;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_enable, grant, busy
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_enable, grant, busy
  );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - packet-level round-robin sharing of one rs232_send transmitter
module rs232_tx_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter bit HEADER_ENABLE = 1'b1,
  parameter int IDLE_TIMEOUT  = 1024
) (
  input logic               clock,
  input logic               reset_n,
  rs232_tx_arbiter_if.slave bus
);
  localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t               state;
  logic [NUM_PORTS-1:0] grant_r;
  logic [3:0]           idx;
  logic [3:0]           last_idx;
  logic [CW-1:0]        cnt;

  logic [NUM_PORTS-1:0] rot;
  logic                 pick_found;
  logic [3:0]           pick_idx;
  int                   sum;
  logic                 g_valid;
  logic                 g_last;
  logic [7:0]           g_data;
  logic                 accept;

  // Rotate so bit 0 is the port right after the last owner; first set bit wins.
  always_comb begin
    rot        = NUM_PORTS'({bus.req_valid, bus.req_valid} >> (last_idx + 4'd1));
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!pick_found && rot[p]) begin
        pick_found = 1'b1;
        sum        = int'(last_idx) + 1 + p;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        pick_idx   = 4'(sum);
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_r[i]) g_data = g_data | bus.req_data[8*i +: 8];
    end
  end

  assign g_valid = |(bus.req_valid & grant_r);
  assign g_last  = |(bus.req_last & grant_r);
  assign accept  = (state == DATA) && g_valid && bus.tx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_r  <= '0;
      idx      <= '0;
      last_idx <= 4'(NUM_PORTS - 1);
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_found) begin
            grant_r <= NUM_PORTS'(1) << pick_idx;
            idx     <= pick_idx;
            state   <= HEADER_ENABLE ? HEADER : DATA;
          end
        end
        HEADER: begin
          cnt <= '0;
          if (bus.tx_ready) state <= DATA;
        end
        DATA: begin
          if (accept) begin
            cnt <= '0;
            if (g_last) begin
              last_idx <= idx;
              grant_r  <= '0;
              state    <= IDLE;
            end
          end else if (IDLE_TIMEOUT > 0 && !g_valid) begin
            // The cycle that would make the count hit the limit is the revoke cycle.
            if (cnt == CW'(IDLE_TIMEOUT - 1)) begin
              last_idx <= idx;
              grant_r  <= '0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.tx_enable = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    case (state)
      HEADER: begin
        bus.tx_enable = 1'b1;
        bus.tx_data   = {4'hA, idx};
      end
      DATA: begin
        bus.tx_enable = g_valid;
        bus.tx_data   = g_data;
        bus.req_ready = grant_r & {NUM_PORTS{bus.tx_ready}};
      end
      default: ;
    endcase
  end

  assign bus.grant = grant_r;
  assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb/tb_rs232_tx_arbiter.sv - scoreboard bench for rs232_tx_arbiter
module tb_rs232_tx_arbiter;
  localparam int NP = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rs232_tx_arbiter_if #(.NUM_PORTS(NP)) bus ();

  rs232_tx_arbiter #(
    .NUM_PORTS(NP), .HEADER_ENABLE(1'b1), .IDLE_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fire_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [8:0]  pq [NP][$];
  logic [11:0] exp_q [$];
  logic [NP-1:0] fire = '0;
  logic txr = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input int port, input logic [7:0] b);
    exp_q.push_back({4'(1 << port), b});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++) if (pq[i].size() != 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  // Requester and transmitter-ready driver: presents queue heads, pops after a handshake.
  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NP; i++) if (fire[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      for (int i = 0; i < NP; i++) begin
        if (pq[i].size() > 0) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_last[i]       = pq[i][0][8];
          bus.req_data[8*i +: 8] = pq[i][0][7:0];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_last[i]       = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
        end
      end
      bus.tx_ready = txr;
      #1;
      fire = bus.req_valid & bus.req_ready;
    end
  end

  // Monitor: every transmitter handshake is popped from the scoreboard and compared.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (reset_n) begin
        check("ready_only_granted", 32'(bus.req_ready & ~bus.grant), 32'h0);
        if (bus.tx_enable && bus.tx_ready) begin
          last_fire_cyc = cyc + 1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got grant=%b data=%h expected none", bus.grant, bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_grant_data", 32'({bus.grant, bus.tx_data}), 32'(e));
          end
        end
      end
    end
  end

  task automatic drain(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    forever begin
      @(negedge clock); #3;
      if (bus.busy) busy_cycles++;
      if (all_empty() && !bus.busy) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got exp_q=%0d expected 0", exp_q.size());
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NP; i++) pq[i].delete();
    exp_q.delete();
    fire = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int bc;
    int n;
    int idle_cyc;
    bit seen;
    bit bad;

    repeat (2) @(negedge clock);
    #1;
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_tx_enable", 32'(bus.tx_enable), 32'h0);
    check("reset_tx_data", 32'(bus.tx_data), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    reset_n = 1'b1;
    @(negedge clock); #3;

    // Single packet on port 2.
    pq[2].push_back({1'b0, 8'h11}); pq[2].push_back({1'b0, 8'h22}); pq[2].push_back({1'b1, 8'h33});
    exp_push(2, 8'hA2); exp_push(2, 8'h11); exp_push(2, 8'h22); exp_push(2, 8'h33);
    drain(bc);
    check("t1_busy_cycles", 32'(bc), 32'd4);
    check("t1_grant_after", 32'(bus.grant), 32'h0);

    // Simultaneous requests from ports 0 and 1 right after reset.
    do_reset();
    #3;
    pq[0].push_back({1'b0, 8'h01}); pq[0].push_back({1'b1, 8'h02});
    pq[1].push_back({1'b0, 8'h03}); pq[1].push_back({1'b1, 8'h04});
    exp_push(0, 8'hA0); exp_push(0, 8'h01); exp_push(0, 8'h02);
    exp_push(1, 8'hA1); exp_push(1, 8'h03); exp_push(1, 8'h04);
    drain(bc);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Round-robin with every port requesting.
    do_reset();
    #3;
    pq[0].push_back({1'b1, 8'h30}); pq[0].push_back({1'b1, 8'h34});
    pq[1].push_back({1'b1, 8'h31});
    pq[2].push_back({1'b1, 8'h32});
    pq[3].push_back({1'b1, 8'h33});
    exp_push(0, 8'hA0); exp_push(0, 8'h30); exp_push(1, 8'hA1); exp_push(1, 8'h31);
    exp_push(2, 8'hA2); exp_push(2, 8'h32); exp_push(3, 8'hA3); exp_push(3, 8'h33);
    exp_push(0, 8'hA0); exp_push(0, 8'h34);
    drain(bc);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure for 50 cycles while 0x52 is presented.
    pq[3].push_back({1'b0, 8'h51}); pq[3].push_back({1'b0, 8'h52}); pq[3].push_back({1'b1, 8'h53});
    exp_push(3, 8'hA3); exp_push(3, 8'h51); exp_push(3, 8'h52); exp_push(3, 8'h53);
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin @(negedge clock); #3; n++; end
    txr = 1'b0;
    @(negedge clock); #3;
    bad = 1'b0;
    repeat (50) begin
      if (bus.tx_data !== 8'h52 || bus.tx_enable !== 1'b1 || bus.req_ready !== '0) bad = 1'b1;
      @(negedge clock); #3;
    end
    check("t4_stall_stable", 32'(bad), 32'h0);
    check("t4_stall_pending", 32'(exp_q.size()), 32'd2);
    txr = 1'b1;
    drain(bc);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: port 1 stalls after one non-last byte; port 2 is waiting.
    pq[1].push_back({1'b0, 8'h61});
    pq[2].push_back({1'b1, 8'h71});
    exp_push(1, 8'hA1); exp_push(1, 8'h61); exp_push(2, 8'hA2); exp_push(2, 8'h71);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin @(negedge clock); #3; if (bus.grant == 4'b0010) seen = 1'b1; n++; end
    check("t5_port1_granted", 32'(seen), 32'h1);
    n = 0;
    while (bus.busy && n < 100) begin @(negedge clock); #3; n++; end
    idle_cyc = cyc;
    check("t5_timeout_cycles", 32'(idle_cyc - last_fire_cyc), 32'd8);
    drain(bc);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a DATA phase.
    pq[3].push_back({1'b0, 8'h81}); pq[3].push_back({1'b0, 8'h82}); pq[3].push_back({1'b1, 8'h83});
    exp_push(3, 8'hA3); exp_push(3, 8'h81); exp_push(3, 8'h82); exp_push(3, 8'h83);
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin @(negedge clock); #3; n++; end
    check("t6_in_data", 32'(bus.grant), 32'b1000);
    reset_n = 1'b0;
    #1;
    check("t6_async_tx_enable", 32'(bus.tx_enable), 32'h0);
    check("t6_async_grant", 32'(bus.grant), 32'h0);
    check("t6_async_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < NP; i++) pq[i].delete();
    exp_q.delete();
    fire = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #3;
    pq[2].push_back({1'b1, 8'h92});
    pq[0].push_back({1'b1, 8'h90});
    exp_push(0, 8'hA0); exp_push(0, 8'h90); exp_push(2, 8'hA2); exp_push(2, 8'h92);
    drain(bc);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
